reg_write_tracer: RTL and testbench

Synthesizable register-write trace unit downstream of the core's register-file write port. It samples every architectural register write (`rd != 0`), timestamps it with a sequence number, buffers it in a small FIFO, and streams it out over a valid/ready interface to a host-side logger or UART serializer. On EBREAK it stops capturing, drains the buffer, and then raises `done`. This is the in-hardware equivalent of the simulation register dump, usable on FPGA.

---
 rtl/trace_pkg.sv | 23 ++
 rtl/trace_fifo.sv | 63 ++++++
 rtl/reg_write_tracer.sv | 108 ++++++++++
 tb/tb_reg_write_tracer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the register-write trace unit.
//   EbreakInsn    : default halting instruction encoding
//   SeqWDefault   : default sequence-number width
//   trace_state_e : capture state machine states
//   trace_entry_t : trace record layout {rd, data, seq} at the default sequence width
package trace_pkg;

   localparam logic [31:0] EbreakInsn  = 32'h00100073;
   localparam int unsigned SeqWDefault = 16;

   typedef enum logic [1:0] {
      StRun,
      StDrain,
      StHalted
   } trace_state_e;

   typedef struct packed {
      logic [4:0]             rd;
      logic [31:0]            data;
      logic [SeqWDefault-1:0] seq;
   } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding trace entries.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   push        : write request; accepted when not full, or when full with a pop in the same cycle
//   push_data   : entry to write
//   pop         : read request; ignored while empty
//   head        : oldest entry, forced to zero while empty
//   full, empty : occupancy flags
module trace_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 53
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned       PtrW      = $clog2(DEPTH);
   localparam logic [PtrW:0]     FullCount = (PtrW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [PtrW:0]    count_q;
   logic             push_fire;
   logic             pop_fire;

   assign empty     = (count_q == '0);
   assign full      = (count_q == FullCount);
   assign pop_fire  = pop && !empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign push_fire = push && (!full || pop_fire);

   // Zero the head while empty so the outputs read as zero after reset.
   assign head = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_fire)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_fire, pop_fire})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; stale contents are never visible.
   always_ff @(posedge clk) begin
      if (push_fire) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/reg_write_tracer.sv
// Register-write trace unit. Captures architectural register writes (rd != 0), tags each with
// a sequence number, buffers them and streams them out over valid/ready. On the halting
// instruction it stops capturing, drains the buffer and then raises done.
// Ports:
//   clk, reset                 : clock and synchronous active-high reset
//   wb_we, wb_rd, wb_data      : register-file write port being observed
//   instr                      : instruction currently in the datapath instruction register
//   out_valid, out_ready       : trace stream handshake
//   out_rd, out_data, out_seq  : head entry of the trace buffer
//   overflow                   : sticky, set when an event was dropped on a full buffer
//   drop_count                 : number of dropped events, saturating at 255
//   done                       : halt seen and buffer fully drained
module reg_write_tracer
   import trace_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned SEQ_W  = SeqWDefault,
   parameter logic [31:0] EBREAK = EbreakInsn
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wb_we,
   input  logic [4:0]       wb_rd,
   input  logic [31:0]      wb_data,
   input  logic [31:0]      instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_rd,
   output logic [31:0]      out_data,
   output logic [SEQ_W-1:0] out_seq,
   output logic             overflow,
   output logic [7:0]       drop_count,
   output logic             done
);

   // Same layout as trace_entry_t, sized by SEQ_W.
   typedef struct packed {
      logic [4:0]       rd;
      logic [31:0]      data;
      logic [SEQ_W-1:0] seq;
   } entry_t;

   trace_state_e     state_q;
   logic [SEQ_W-1:0] seq_q;
   logic             overflow_q;
   logic [7:0]       drop_count_q;

   entry_t push_entry;
   entry_t head_entry;
   logic   fifo_full;
   logic   fifo_empty;
   logic   capture;
   logic   pop_fire;
   logic   drop;
   logic   push_ok;

   assign capture  = wb_we && (wb_rd != 5'd0) && (state_q == StRun);
   assign pop_fire = out_valid && out_ready;
   assign drop     = capture && fifo_full && !pop_fire;
   assign push_ok  = capture && !drop;

   assign push_entry = '{rd: wb_rd, data: wb_data, seq: seq_q};

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (capture),
      .push_data (push_entry),
      .pop       (pop_fire),
      .head      (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign out_valid  = !fifo_empty;
   assign out_rd     = head_entry.rd;
   assign out_data   = head_entry.data;
   assign out_seq    = head_entry.seq;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;
   assign done       = (state_q == StHalted);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StRun;
         seq_q        <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= 8'd0;
      end else begin
         // Sequence numbers mark accepted entries only, so gaps never appear in the stream.
         if (push_ok) seq_q <= seq_q + 1'b1;
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
         end
         case (state_q)
            StRun:    if (instr == EBREAK) state_q <= StDrain;
            StDrain:  if (fifo_empty && !pop_fire) state_q <= StHalted;
            StHalted: state_q <= StHalted;
            default:  state_q <= StRun;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_write_tracer.sv
module tb_reg_write_tracer;

   localparam int unsigned DEPTH   = 8;
   localparam int unsigned SEQ_W   = 16;
   localparam logic [31:0] EBK     = 32'h00100073;

   logic             clk;
   logic             reset;
   logic             wb_we;
   logic [4:0]       wb_rd;
   logic [31:0]      wb_data;
   logic [31:0]      instr;
   logic             out_valid;
   logic             out_ready;
   logic [4:0]       out_rd;
   logic [31:0]      out_data;
   logic [SEQ_W-1:0] out_seq;
   logic             overflow;
   logic [7:0]       drop_count;
   logic             done;

   reg_write_tracer #(
      .DEPTH  (DEPTH),
      .SEQ_W  (SEQ_W),
      .EBREAK (EBK)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wb_we      (wb_we),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .instr      (instr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_rd     (out_rd),
      .out_data   (out_data),
      .out_seq    (out_seq),
      .overflow   (overflow),
      .drop_count (drop_count),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic [15:0] seq;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: occupancy, next sequence number, drop tally, mode (0 run, 1 drain, 2 halted).
   int   m_occ   = 0;
   int   m_seq   = 0;
   int   m_drops = 0;
   bit   m_ovf   = 1'b0;
   int   m_mode  = 0;

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard monitor: every handshake must deliver the oldest expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_entry", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("head_rd", out_rd, e.rd);
               check("head_data", out_data, e.data);
               check("head_seq", out_seq, e.seq);
            end
         end
      end
   end

   task automatic do_reset();
      reset     = 1'b1;
      wb_we     = 1'b0;
      wb_rd     = 5'd0;
      wb_data   = 32'd0;
      instr     = 32'd0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      reset   = 1'b0;
      m_occ   = 0;
      m_seq   = 0;
      m_drops = 0;
      m_ovf   = 1'b0;
      m_mode  = 0;
      exp_q.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_rd", out_rd, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_seq", out_seq, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drop_count", drop_count, 0);
      check("rst_done", done, 0);
   endtask

   // One clock cycle of stimulus; the model advances alongside and flags are checked after the edge.
   task automatic step(input bit we, input logic [4:0] rd, input logic [31:0] data,
                       input logic [31:0] ins, input bit ready);
      bit pop;
      bit cap;
      bit accept;
      int nmode;
      wb_we     = we;
      wb_rd     = rd;
      wb_data   = data;
      instr     = ins;
      out_ready = ready;
      pop    = (m_occ > 0) && ready;
      cap    = we && (rd != 5'd0) && (m_mode == 0);
      accept = cap && ((m_occ < DEPTH) || pop);
      if (accept) exp_q.push_back('{rd, data, 16'(m_seq)});
      nmode = m_mode;
      if (m_mode == 0 && ins == EBK) nmode = 1;
      else if (m_mode == 1 && m_occ == 0) nmode = 2;
      @(posedge clk);
      #1;
      m_occ = m_occ - int'(pop) + int'(accept);
      if (accept) m_seq = (m_seq + 1) % 65536;
      if (cap && !accept) begin
         m_ovf = 1'b1;
         if (m_drops < 255) m_drops++;
      end
      m_mode = nmode;
      check("out_valid", out_valid, m_occ > 0);
      check("done", done, m_mode == 2);
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_drops);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
   endtask

   task automatic rand_steps(input int n);
      logic [31:0] ins;
      for (int i = 0; i < n; i++) begin
         ins = $urandom;
         if (ins == EBK) ins = 32'd0;
         step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom, ins,
              $urandom_range(0, 2) != 0);
      end
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && !done; i++) step(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
      check("done_reached", done, 1);
   endtask

   initial begin
      do_reset();

      // Basic capture, one entry per cycle.
      step(1'b1, 5'd5, 32'h0000002A, 32'd0, 1'b1);
      step(1'b1, 5'd6, 32'hDEADBEEF, 32'd0, 1'b1);
      idle(2);
      check("basic_overflow", overflow, 0);

      // Writes to x0 are filtered and do not consume a sequence number.
      step(1'b1, 5'd0, 32'h12345678, 32'd0, 1'b1);
      check("x0_no_entry", out_valid, 0);
      step(1'b1, 5'd7, 32'h00001111, 32'd0, 1'b1);
      idle(2);

      // Overflow: ten writes into an eight-entry buffer with the consumer stalled.
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b1, 5'(i + 1), $urandom, 32'd0, 1'b0);
      check("ovf_flag", overflow, 1);
      check("ovf_drops", drop_count, 2);
      check("ovf_head_seq", out_seq, 0);
      // Full with simultaneous pop: the write is accepted.
      step(1'b1, 5'd20, 32'hCAFE0000, 32'd0, 1'b1);
      check("full_pushpop_drops", drop_count, 2);
      idle(12);
      check("ovf_drained", exp_q.size(), 0);

      // Randomized traffic.
      do_reset();
      rand_steps(400);
      idle(12);
      check("rand_drained", exp_q.size(), 0);

      // Halt with three entries pending; later writes are ignored.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 5'(10 + i), $urandom, 32'd0, 1'b0);
      step(1'b0, 5'd0, 32'd0, EBK, 1'b1);
      step(1'b1, 5'd9, 32'h99999999, 32'd0, 1'b1);
      wait_done(20);
      check("ebrk_drops", drop_count, 0);
      check("ebrk_drained", exp_q.size(), 0);

      // Halt on an empty buffer: done two edges after the halt is sampled.
      do_reset();
      step(1'b0, 5'd0, 32'd0, EBK, 1'b0);
      check("ebrk_empty_edge1", done, 0);
      step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
      check("ebrk_empty_edge2", done, 1);

      // Halt with a write in the same cycle: that write is still captured.
      do_reset();
      step(1'b1, 5'd4, 32'h44444444, EBK, 1'b1);
      wait_done(10);

      // Reset during drain discards pending entries and restarts the sequence.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 5'(1 + i), $urandom, 32'd0, 1'b0);
      step(1'b0, 5'd0, 32'd0, EBK, 1'b0);
      step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
      do_reset();
      step(1'b1, 5'd3, 32'h00000055, 32'd0, 1'b1);
      check("post_rst_seq", out_seq, 0);
      idle(2);
      check("post_rst_drained", exp_q.size(), 0);

      // Random traffic ending with a halt.
      do_reset();
      rand_steps(200);
      step(1'b0, 5'd0, 32'd0, EBK, 1'b1);
      wait_done(40);
      check("final_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
